// File: rtl/random_range_generator.sv
// XNOR-feedback LFSR random source with reseed, lock-up protection, period pulse
// and a rejection-sampling draw port returning unbiased values in [0, draw_limit].
module random_range_generator #(
    parameter int                  NUM_BITS  = 32,
    parameter int                  OUT_BITS  = 8,
    parameter logic [NUM_BITS-1:0] SEED      = '0,
    parameter int                  MAX_TRIES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                seed_load,
    input  logic [NUM_BITS-1:0] seed_value,
    output logic [NUM_BITS-1:0] random,
    output logic                period_done,
    input  logic                draw_req,
    input  logic [OUT_BITS-1:0] draw_limit,
    output logic                draw_ready,
    output logic                draw_valid,
    output logic [OUT_BITS-1:0] draw_value,
    input  logic                draw_ack
);

    // Maximal-length tap sets (XAPP052), bit k-1 set for tap k.
    function automatic logic [31:0] tap_mask(input int n);
        logic [31:0] m;
        case (n)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    localparam logic [31:0]          TAPS_FULL   = tap_mask(NUM_BITS);
    localparam logic [NUM_BITS-1:0]  TAPS        = TAPS_FULL[NUM_BITS-1:0];
    localparam logic [NUM_BITS-1:0]  ALL_ONES    = '1;
    localparam logic [NUM_BITS-1:0]  CNT_LAST    = ALL_ONES - NUM_BITS'(1);
    localparam logic [NUM_BITS-1:0]  RESET_STATE = (SEED == ALL_ONES) ? '0 : SEED;
    localparam int                   TRY_W       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]     LAST_TRY    = TRY_W'(MAX_TRIES - 1);
    localparam logic [OUT_BITS-1:0]  ONE_OUT     = OUT_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_RESP
    } state_t;

    state_t              state_reg;
    logic [NUM_BITS-1:0] lfsr_reg;
    logic [NUM_BITS-1:0] step_cnt_reg;
    logic                period_done_reg;
    logic [OUT_BITS-1:0] limit_reg;
    logic [OUT_BITS-1:0] mask_reg;
    logic [OUT_BITS-1:0] value_reg;
    logic [TRY_W-1:0]    tries_reg;
    logic                ready_reg;
    logic                valid_reg;

    logic                feedback;
    logic [NUM_BITS-1:0] lfsr_next;
    logic [NUM_BITS-1:0] seed_safe;
    logic                step;
    logic [OUT_BITS-1:0] limit_mask;
    logic [OUT_BITS-1:0] candidate;
    logic [OUT_BITS-1:0] fallback;

    assign feedback  = ~(^(lfsr_reg & TAPS));
    assign lfsr_next = {lfsr_reg[NUM_BITS-2:0], feedback};
    // The all-ones state would lock an XNOR LFSR, so it is never loaded.
    assign seed_safe = (seed_value == ALL_ONES) ? '0 : seed_value;
    assign step      = enable || (state_reg == ST_DRAW);

    // Smallest 2^k-1 covering the limit: bit i set if any limit bit at or above i is set.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_BITS; gi++) begin : g_mask
            assign limit_mask[gi] = |draw_limit[OUT_BITS-1:gi];
        end
    endgenerate

    assign candidate = lfsr_reg[OUT_BITS-1:0] & mask_reg;
    // candidate <= mask < 2*limit+1 whenever rejected, so this stays within [0, limit].
    assign fallback  = candidate - (limit_reg + ONE_OUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg        <= RESET_STATE;
            step_cnt_reg    <= '0;
            period_done_reg <= 1'b0;
            state_reg       <= ST_IDLE;
            limit_reg       <= '0;
            mask_reg        <= '0;
            value_reg       <= '0;
            tries_reg       <= '0;
            ready_reg       <= 1'b1;
            valid_reg       <= 1'b0;
        end else begin
            period_done_reg <= 1'b0;
            if (seed_load) begin
                lfsr_reg     <= seed_safe;
                step_cnt_reg <= '0;
            end else if (step) begin
                lfsr_reg <= lfsr_next;
                if (step_cnt_reg == CNT_LAST) begin
                    step_cnt_reg    <= '0;
                    period_done_reg <= 1'b1;
                end else begin
                    step_cnt_reg <= step_cnt_reg + NUM_BITS'(1);
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (draw_req) begin
                        limit_reg <= draw_limit;
                        mask_reg  <= limit_mask;
                        tries_reg <= '0;
                        ready_reg <= 1'b0;
                        state_reg <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (candidate <= limit_reg) begin
                        value_reg <= candidate;
                        valid_reg <= 1'b1;
                        state_reg <= ST_RESP;
                    end else if (tries_reg == LAST_TRY) begin
                        value_reg <= fallback;
                        valid_reg <= 1'b1;
                        state_reg <= ST_RESP;
                    end else begin
                        tries_reg <= tries_reg + TRY_W'(1);
                    end
                end
                ST_RESP: begin
                    if (draw_ack) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign random      = lfsr_reg;
    assign period_done = period_done_reg;
    assign draw_ready  = ready_reg;
    assign draw_valid  = valid_reg;
    assign draw_value  = value_reg;

endmodule

// File: tb/tb_random_range_generator.sv
// Bench for random_range_generator: a 4-bit instance with a cycle model and draw
// scoreboard, plus an 8-bit MAX_TRIES=1 instance exercising the fallback path.
module tb_random_range_generator;

    logic       clk = 1'b0;
    logic       reset;

    logic       a_enable, a_seed_load, a_draw_req, a_draw_ack;
    logic [3:0] a_seed_value, a_draw_limit;
    logic [3:0] a_random, a_draw_value;
    logic       a_period_done, a_draw_ready, a_draw_valid;

    logic       b_enable, b_seed_load, b_draw_req, b_draw_ack;
    logic [7:0] b_seed_value, b_random;
    logic [3:0] b_draw_limit, b_draw_value;
    logic       b_period_done, b_draw_ready, b_draw_valid;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] m_lfsr;
    int         m_cnt;
    int         m_draw_left;
    int         exp_val_q[$];
    int         exp_lat_q[$];
    int         hist[16];

    always #5 clk = ~clk;

    random_range_generator #(.NUM_BITS(4), .OUT_BITS(4), .SEED(4'h0), .MAX_TRIES(16)) dut_a (
        .clk(clk), .reset(reset), .enable(a_enable), .seed_load(a_seed_load),
        .seed_value(a_seed_value), .random(a_random), .period_done(a_period_done),
        .draw_req(a_draw_req), .draw_limit(a_draw_limit), .draw_ready(a_draw_ready),
        .draw_valid(a_draw_valid), .draw_value(a_draw_value), .draw_ack(a_draw_ack)
    );

    random_range_generator #(.NUM_BITS(8), .OUT_BITS(4), .SEED(8'h00), .MAX_TRIES(1)) dut_b (
        .clk(clk), .reset(reset), .enable(b_enable), .seed_load(b_seed_load),
        .seed_value(b_seed_value), .random(b_random), .period_done(b_period_done),
        .draw_req(b_draw_req), .draw_limit(b_draw_limit), .draw_ready(b_draw_ready),
        .draw_valid(b_draw_valid), .draw_value(b_draw_value), .draw_ack(b_draw_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] nxt4(input logic [3:0] s);
        return {s[2:0], ~(s[3] ^ s[2])};
    endfunction

    function automatic logic [7:0] nxt8(input logic [7:0] s);
        return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
    endfunction

    // Walk future LFSR states to find the result and the number of DRAW cycles.
    task automatic predict(input logic [3:0] s0, input int lim, input int max_tries,
                           output int val, output int tries);
        int m;
        int c;
        logic [3:0] s;
        m = 0;
        s = s0;
        val = 0;
        tries = max_tries;
        while (m < lim) m = m * 2 + 1;
        for (int k = 0; k < max_tries; k++) begin
            c = int'(s) & m;
            if (c <= lim) begin
                val = c;
                tries = k + 1;
                return;
            end
            if (k == max_tries - 1) begin
                val = c - lim - 1;
                tries = k + 1;
                return;
            end
            s = nxt4(s);
        end
    endtask

    // One clock: update the model from the inputs held this cycle, then compare.
    task automatic tick();
        logic pd;
        pd = 1'b0;
        if (reset) begin
            m_lfsr = 4'h0;
            m_cnt = 0;
            m_draw_left = 0;
        end else begin
            if (a_seed_load) begin
                m_lfsr = (a_seed_value == 4'hF) ? 4'h0 : a_seed_value;
                m_cnt = 0;
            end else if (a_enable || m_draw_left > 0) begin
                m_lfsr = nxt4(m_lfsr);
                if (m_cnt == 14) begin
                    m_cnt = 0;
                    pd = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            if (m_draw_left > 0) m_draw_left--;
        end
        @(posedge clk);
        #1;
        check("random", a_random, m_lfsr);
        check("period_done", a_period_done, pd);
    endtask

    task automatic accept(input int lim);
        int v;
        int t;
        a_draw_limit = lim[3:0];
        a_draw_req = 1'b1;
        tick();
        a_draw_req = 1'b0;
        a_draw_limit = 4'($urandom);
        predict(m_lfsr, lim, 16, v, t);
        m_draw_left = t;
        exp_val_q.push_back(v);
        exp_lat_q.push_back(t);
        check("ready_busy", a_draw_ready, 1'b0);
    endtask

    task automatic do_draw(input int lim, input bit poke);
        int lat;
        int ev;
        int el;
        logic [3:0] got;
        accept(lim);
        lat = 0;
        while (!a_draw_valid && lat < 40) begin
            tick();
            lat++;
        end
        ev = exp_val_q.pop_front();
        el = exp_lat_q.pop_front();
        got = a_draw_value;
        check("latency", lat, el);
        check("value", got, ev);
        check("ready_resp", a_draw_ready, 1'b0);
        if (poke) begin
            a_draw_req = 1'b1;
            a_draw_limit = 4'h0;
            tick();
            a_draw_req = 1'b0;
            check("hold_valid", a_draw_valid, 1'b1);
            check("hold_value", a_draw_value, ev);
        end
        a_draw_ack = 1'b1;
        tick();
        a_draw_ack = 1'b0;
        check("valid_clr", a_draw_valid, 1'b0);
        check("ready_set", a_draw_ready, 1'b1);
        if (poke) begin
            tick();
            check("req_not_queued_ready", a_draw_ready, 1'b1);
            check("req_not_queued_valid", a_draw_valid, 1'b0);
        end
        hist[got]++;
        $display("draw limit=%0d value=%0d expected=%0d latency=%0d", lim, got, ev, lat);
    endtask

    initial begin
        logic [3:0] seq [4];
        int pulses;
        int over;
        int lat;
        int ev;
        seq = '{4'h1, 4'h3, 4'h7, 4'hE};
        reset = 1'b1;
        a_enable = 0; a_seed_load = 0; a_draw_req = 0; a_draw_ack = 0;
        a_seed_value = 0; a_draw_limit = 0;
        b_enable = 0; b_seed_load = 0; b_draw_req = 0; b_draw_ack = 0;
        b_seed_value = 0; b_draw_limit = 0;
        m_lfsr = 0; m_cnt = 0; m_draw_left = 0;
        foreach (hist[i]) hist[i] = 0;

        tick();
        tick();
        check("rst_random", a_random, 4'h0);
        check("rst_ready", a_draw_ready, 1'b1);
        check("rst_valid", a_draw_valid, 1'b0);
        check("rst_value", a_draw_value, 4'h0);
        check("rst_pd", a_period_done, 1'b0);
        reset = 1'b0;
        $display("reset released");

        a_enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (i < 4) check("seq", a_random, seq[i]);
            if (a_period_done) pulses++;
        end
        check("pulse_count", pulses, 2);
        $display("free-run 35 steps, period pulses=%0d", pulses);

        a_seed_value = 4'hF;
        a_seed_load = 1'b1;
        tick();
        check("seed_ones", a_random, 4'h0);
        a_seed_value = 4'h5;
        tick();
        check("seed_wins", a_random, 4'h5);
        a_seed_load = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        $display("seed tests done");
        a_enable = 1'b0;

        a_draw_ack = 1'b1;
        tick();
        a_draw_ack = 1'b0;
        check("ack_idle_ready", a_draw_ready, 1'b1);
        check("ack_idle_valid", a_draw_valid, 1'b0);

        do_draw(0, 1'b0);
        do_draw(15, 1'b1);
        do_draw(7, 1'b0);
        do_draw(2, 1'b1);
        foreach (hist[i]) hist[i] = 0;
        for (int i = 0; i < 1000; i++) begin
            a_enable = 1'($urandom_range(0, 1));
            do_draw(5, 1'b0);
        end
        a_enable = 1'b0;
        over = 0;
        for (int i = 6; i < 16; i++) over += hist[i];
        check("hist_over", over, 0);
        for (int i = 0; i < 6; i++) check("hist_seen", hist[i] > 0, 1'b1);

        // Reset in DRAW, then in RESP: draw aborted with no response.
        accept(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_val_q.delete();
        exp_lat_q.delete();
        check("rst_draw_valid", a_draw_valid, 1'b0);
        check("rst_draw_ready", a_draw_ready, 1'b1);
        check("rst_draw_random", a_random, 4'h0);
        check("rst_draw_pd", a_period_done, 1'b0);
        $display("reset during DRAW");
        accept(15);
        tick();
        check("resp_reached", a_draw_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_val_q.delete();
        exp_lat_q.delete();
        check("rst_resp_valid", a_draw_valid, 1'b0);
        check("rst_resp_ready", a_draw_ready, 1'b1);
        check("rst_resp_random", a_random, 4'h0);
        check("rst_resp_pd", a_period_done, 1'b0);
        $display("reset during RESP");

        // Fallback path: single try, low bits 7, limit 4 -> 7-5 = 2.
        b_seed_value = 8'h07;
        b_seed_load = 1'b1;
        tick();
        b_seed_load = 1'b0;
        check("b_seed", b_random, 8'h07);
        b_draw_limit = 4'd4;
        b_draw_req = 1'b1;
        tick();
        b_draw_req = 1'b0;
        exp_val_q.push_back(2);
        exp_lat_q.push_back(1);
        check("b_ready_busy", b_draw_ready, 1'b0);
        lat = 0;
        while (!b_draw_valid && lat < 40) begin
            tick();
            lat++;
        end
        ev = exp_val_q.pop_front();
        check("b_latency", lat, exp_lat_q.pop_front());
        check("b_value", b_draw_value, ev);
        check("b_random_stepped", b_random, nxt8(8'h07));
        b_draw_ack = 1'b1;
        tick();
        b_draw_ack = 1'b0;
        check("b_valid_clr", b_draw_valid, 1'b0);
        check("b_ready_set", b_draw_ready, 1'b1);
        $display("fallback draw limit=4 value=%0d expected=%0d latency=%0d", b_draw_value, ev, lat);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
